// File: rtl/multi_shift_reg.sv
// multi_shift_reg: N-bit shift/rotate register with a valid/ready command handshake.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   cmd_valid  command request; accepted when cmd_valid && cmd_ready
//   cmd_ready  high while idle (a command can be accepted)
//   mode       000 HOLD, 001 SRL, 010 SLL, 011 LOAD, 100 ROR, 101 ROL, 110 SRA, 111 HOLD
//   amt        shift/rotate count (0..2^AMT_W-1, may exceed N)
//   in         parallel load data
//   MSB_in     serial fill for right shifts
//   LSB_in     serial fill for left shifts
//   Q          register contents
//   ser_out    last bit shifted out of Q
//   busy       multi-cycle shift in progress
//   done       one-cycle completion pulse
//
// Build option
//   MULTI_SHIFT_REG_BARREL_EN: when defined, shift/rotate commands finish in the accept cycle
//   through a combinational shifter and the SHIFT state is never entered. When undefined
//   (default), a k-bit shift runs one bit per clock.

module multi_shift_reg #(
    parameter int unsigned N     = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [N-1:0]     in,
    input  logic             MSB_in,
    input  logic             LSB_in,
    output logic [N-1:0]     Q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] ModeHold = 3'b000;
    localparam logic [2:0] ModeSrl  = 3'b001;
    localparam logic [2:0] ModeSll  = 3'b010;
    localparam logic [2:0] ModeLoad = 3'b011;
    localparam logic [2:0] ModeRor  = 3'b100;
    localparam logic [2:0] ModeRol  = 3'b101;
    localparam logic [2:0] ModeSra  = 3'b110;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     q_q, q_d;
    logic             ser_q, ser_d;
    logic             done_q, done_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    logic             accept;
    logic             is_shift;
    logic             start_iter;
    logic [N-1:0]     q_step;
    logic             ser_step;

    // One 1-bit operation; returns {exiting bit, new register value}.
    function automatic logic [N:0] step1(input logic [2:0] op, input logic [N-1:0] q,
                                         input logic msb, input logic lsb);
        logic [N:0] r;
        case (op)
            ModeSrl: r = {q[0], msb, q[N-1:1]};
            ModeSll: r = {q[N-1], q[N-2:0], lsb};
            ModeRor: r = {q[0], q[0], q[N-1:1]};
            ModeRol: r = {q[N-1], q[N-2:0], q[N-1]};
            ModeSra: r = {q[0], q[N-1], q[N-1:1]};
            default: r = {1'b0, q};
        endcase
        return r;
    endfunction

`ifdef MULTI_SHIFT_REG_BARREL_EN
    // Whole k-bit operation in one step; matches k iterations of step1 with constant fill.
    function automatic logic [N:0] barrel(input logic [2:0] op, input logic [N-1:0] q,
                                          input logic [AMT_W-1:0] k, input logic msb,
                                          input logic lsb);
        int unsigned  kk;
        int unsigned  r;
        logic [N-1:0] ones;
        logic [N-1:0] res;
        logic [N-1:0] tmp;
        logic         s;
        kk   = 32'(k);
        r    = kk % N;
        ones = '1;
        res  = q;
        s    = 1'b0;
        case (op)
            ModeSrl: begin
                res = (kk >= N) ? {N{msb}} : ((q >> kk) | (~(ones >> kk) & {N{msb}}));
                tmp = q >> (kk - 1);
                s   = (kk > N) ? msb : tmp[0];
            end
            ModeSll: begin
                res = (kk >= N) ? {N{lsb}} : ((q << kk) | (~(ones << kk) & {N{lsb}}));
                tmp = q << (kk - 1);
                s   = (kk > N) ? lsb : tmp[N-1];
            end
            ModeSra: begin
                res = (kk >= N) ? {N{q[N-1]}} : ($signed(q) >>> kk);
                tmp = q >> (kk - 1);
                s   = (kk > N) ? q[N-1] : tmp[0];
            end
            ModeRor: begin
                res = (q >> r) | (q << (N - r));
                s   = res[N-1];
            end
            ModeRol: begin
                res = (q << r) | (q >> (N - r));
                s   = res[0];
            end
            default: begin
                res = q;
                s   = 1'b0;
            end
        endcase
        return {s, res};
    endfunction
`endif

    assign accept   = cmd_valid && (state_q == StIdle);
    assign is_shift = mode inside {ModeSrl, ModeSll, ModeRor, ModeRol, ModeSra};

`ifdef MULTI_SHIFT_REG_BARREL_EN
    assign start_iter = 1'b0;
`else
    assign start_iter = accept && is_shift && (amt != '0);
`endif

    assign {ser_step, q_step} = step1(op_q, q_q, MSB_in, LSB_in);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_iter) state_d = StShift;
            StShift: if (cnt_q == AMT_W'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        q_d    = q_q;
        ser_d  = ser_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (mode == ModeLoad) begin
                        q_d    = in;
                        done_d = 1'b1;
                    end else if (!is_shift || (amt == '0)) begin
                        // HOLD, reserved, or zero-length shift: completes immediately
                        done_d = 1'b1;
                    end else begin
`ifdef MULTI_SHIFT_REG_BARREL_EN
                        {ser_d, q_d} = barrel(mode, q_q, amt, MSB_in, LSB_in);
                        done_d       = 1'b1;
`else
                        op_d  = mode;
                        cnt_d = amt;
`endif
                    end
                end
            end
            StShift: begin
                q_d   = q_step;
                ser_d = ser_step;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= '0;
            ser_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= ModeHold;
        end else begin
            q_q    <= q_d;
            ser_q  <= ser_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
        end
    end

    // Outputs
    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q == StShift);
        Q         = q_q;
        ser_out   = ser_q;
        done      = done_q;
    end

endmodule

// File: doc/multi_shift_reg.md
Name: multi_shift_reg

Overview:
Parametrised successor to the 4-bit universal shift register, holding an N-bit register with a command handshake.
- Adds rotate and arithmetic-shift modes, multi-bit shift amounts, a serial output, and busy/done status.
- Default build executes a k-bit shift iteratively, one bit per clock.
- Used by serialisers and bit-manipulation datapaths that need shift-by-k without an external counter.

Parameters:
N, 8, register width (N >= 2)
AMT_W, 4, width of shift-amount field; amounts 0..2^AMT_W-1 are legal, including values >= N

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command
mode  input  3  operation code (see Behaviour)
amt  input  AMT_W  shift count for shift/rotate modes
in  input  N  parallel load data
MSB_in  input  1  serial fill for right shifts
LSB_in  input  1  serial fill for left shifts
Q  output  N  register contents
ser_out  output  1  last bit shifted out of Q
busy  output  1  shift in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous, active-low.
- Reset values: Q=0, ser_out=0, busy=0, done=0, cmd_ready=1, FSM=IDLE, internal counter=0.
- Mode encoding (000-011 match the predecessor):
  - 000 HOLD
  - 001 SRL, MSB_in fill
  - 010 SLL, LSB_in fill
  - 011 LOAD
  - 100 ROR
  - 101 ROL
  - 110 SRA, Q[N-1] replicated
  - 111 reserved, treated as HOLD
- Handshake:
  - Command accepted at an edge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE); busy = (state==SHIFT).
  - cmd_valid while busy is ignored and not queued. mode/amt/in are sampled only at acceptance.
- FSM states: IDLE, SHIFT.
- IDLE, accepting HOLD/reserved/LOAD, or any shift mode with amt=0:
  - Completes at the acceptance edge E0; LOAD sets Q<=in, all others leave Q unchanged.
  - done=1 for the cycle after E0. State stays IDLE. ser_out unchanged.
- IDLE, accepting a shift/rotate mode with amt=k>0:
  - Latch mode, set counter=k, go to SHIFT. Q unchanged at E0.
- SHIFT state:
  - Each edge performs one 1-bit operation on Q and decrements the counter.
  - MSB_in/LSB_in are sampled live at each shift edge.
  - ser_out <= exiting bit at each shift edge: Q[0] for SRL/ROR/SRA, Q[N-1] for SLL/ROL.
  - At the edge where counter==1: final shift, state->IDLE, done<=1 for one cycle.
- Latency: accept at E0, shifts at E1..Ek, done and cmd_ready high in the cycle after Ek. Next command is accepted no earlier than Ek+1.
- amt >= N:
  - Rotates wrap naturally (net rotate by k mod N).
  - SRL/SLL fill Q entirely with serial input.
  - SRA saturates to all copies of the sign bit.
- done is never asserted without a preceding accepted command.
- Reset mid-operation: immediate return to reset values. The aborted command produces no done.

Optional Feature:
Macro: MULTI_SHIFT_REG_BARREL_EN
- Defined: shift/rotate commands complete at E0 via a combinational barrel shifter, and the SHIFT state is unused.
  - busy stays 0; done=1 in the cycle after E0.
  - MSB_in/LSB_in are sampled once at E0 and used as a constant fill.
  - Final Q and ser_out must equal iterative mode with constant serial inputs: rotate by k mod N; logical shift with k>=N gives all-fill and ser_out=fill bit (k>N) or the original edge bit (k=N).
- Undefined: iterative behaviour as above.
- Gate count and timing differ between builds; command interface is identical.

Test Plan:
1. Assert reset_n=0 mid-idle -> Q=0x00, cmd_ready=1, busy=0, done=0, ser_out=0.
2. LOAD in=0xA5 -> Q=0xA5 after E0, done high exactly 1 cycle, busy never high.
3. From 0xA5, SRL amt=3 MSB_in=1 -> Q: 0xD2, 0xE9, 0xF4 on E1..E3; ser_out=1; busy 3 cycles; done in the cycle after E3. Barrel build: Q=0xF4, done the cycle after E0.
4. From 0x81, ROL amt=9 -> Q=0x03 after 9 shifts, ser_out=1, busy 9 cycles.
5. From 0x90, SRA amt=2, with LOAD in=0x00 driven during busy -> Q=0xE4, LOAD ignored, exactly one done.
6. SLL amt=7 LSB_in=0 from 0xFF, reset_n low after E3 -> Q=0x00, busy=0; no done after release; next LOAD accepted normally.
